full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter REG_OUT, default 1, where 1 means the registered outputs are present and 0 means they are tied to 0.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1, the single clock; all registers update on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port en, input, 1, load enable for the registered outputs.
REQ-007 Port a, input, WIDTH, addend A (unsigned).
REQ-008 Port b, input, WIDTH, addend B (unsigned).
REQ-009 Port cin, input, 1, carry-in.
REQ-010 Port sum, output, WIDTH, combinational sum.
REQ-011 Port carry, output, 1, combinational carry-out.
REQ-012 Port sum_r, output, WIDTH, registered sum.
REQ-013 Port carry_r, output, 1, registered carry-out.

Function
REQ-014 {carry, sum} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-015 At WIDTH=1, sum SHALL be a XOR b XOR cin, and carry SHALL be (a AND b) OR (cin AND (a XOR b)).
REQ-016 sum and carry SHALL be purely combinational (zero latency): no clock, reset or en dependency, and settled within the same time step as an input change.
REQ-017 The block SHALL compute sum/carry as a ripple chain of WIDTH 1-bit cells, with cell i taking carry from cell i-1, cell 0 taking cin, and carry taken from cell WIDTH-1.
REQ-018 Overflow SHALL wrap: sum holds the low WIDTH bits, and carry=1 SHALL flag the unsigned overflow.
REQ-019 On a rising clk edge with rst=0 and en=1, sum_r/carry_r SHALL capture the current sum/carry, giving 1-cycle latency.
REQ-020 On a rising clk edge with rst=0 and en=0, sum_r/carry_r SHALL hold their values.
REQ-021 When REG_OUT=0, sum_r and carry_r SHALL be constant 0 and no registers SHALL be inferred.
REQ-022 X/Z on any input SHALL NOT be masked; the outputs propagate X.

Reset
REQ-023 While rst=1 at a rising clk edge, sum_r SHALL become 0 and carry_r SHALL become 0.
REQ-024 rst SHALL take priority over en when both are 1 at the same edge.
REQ-025 rst SHALL NOT affect the combinational sum/carry.
REQ-026 There SHALL be no asynchronous reset path; asserting rst between edges SHALL leave sum_r/carry_r unchanged until the next edge.
REQ-027 The first edge after rst deasserts SHALL load normally when en=1.

Structure
REQ-028 Package full_adder_pkg SHALL hold the default WIDTH constant (1), the maximum width constant (64), and a function returning the reference (WIDTH+1)-bit sum for checkers.
REQ-029 A single sub-module full_adder_cell SHALL implement the 1-bit equations of REQ-015, instantiated WIDTH times by a generate loop.
REQ-030 The output registers SHALL live in the top module inside a generate block gated by REG_OUT.

Verification
REQ-031 At WIDTH=1, the bench SHALL apply all 8 {a,b,cin} combinations at 5-time-unit spacing and SHALL require: 000->s0c0, 010->s1c0, 100->s1c0, 110->s0c1, 011->s0c1, 101->s0c1, 111->s1c1, 001->s1c0.
REQ-032 At WIDTH=8, the bench SHALL apply a=0xFF, b=0x01, cin=0 and SHALL require sum=0x00, carry=1; it SHALL then apply a=0x7F, b=0x80, cin=1 and SHALL require sum=0x00, carry=1.
REQ-033 The bench SHALL hold rst=1 for 2 edges with en=1 and a=b=cin=1, and SHALL require sum_r=0 and carry_r=0 while the combinational outputs read sum=1, carry=1.
REQ-034 The bench SHALL apply en=1 with a=1, b=0, cin=0 for one edge, then en=0 with a=b=cin=1; it SHALL require sum_r=1, carry_r=0 to persist across the en=0 edges.
REQ-035 The bench SHALL assert rst=1 and en=1 at the same edge and SHALL require sum_r=0, carry_r=0; after rst drops it SHALL require the next edge to load the current sum/carry.
REQ-036 At WIDTH=16, the bench SHALL drive 1000 random vectors checked against the full_adder_pkg reference function and SHALL require zero mismatches.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and the golden (WIDTH+1)-bit addition used by checkers.
package full_adder_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH     = 64;

  // Operands are masked to 'width' bits; the result keeps width+1 bits (carry on top).
  function automatic logic [FA_MAX_WIDTH:0] fa_ref_sum(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin,
    input int unsigned             width
  );
    logic [FA_MAX_WIDTH:0] mask;
    logic [FA_MAX_WIDTH:0] res_mask;
    logic [FA_MAX_WIDTH:0] full;
    mask     = {(FA_MAX_WIDTH+1){1'b1}} >> (FA_MAX_WIDTH + 1 - width);
    res_mask = (mask << 1) | {{FA_MAX_WIDTH{1'b0}}, 1'b1};
    full     = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{FA_MAX_WIDTH{1'b0}}, cin};
    return full & res_mask;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder cell; one link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic half;

  always_comb begin
    half  = a ^ b;
    sum   = half ^ cin;
    carry = (a & b) | (cin & half);
  end

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with optional enable-gated output registers.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = FA_DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_r,
  output logic             carry_r
);

  logic [WIDTH:0] chain;

  assign chain[0] = cin;
  assign carry    = chain[WIDTH];

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .cin   (chain[i]),
      .sum   (sum[i]),
      .carry (chain[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_r_d, sum_r_q;
    logic             carry_r_d, carry_r_q;

    always_comb begin
      sum_r_d   = sum_r_q;
      carry_r_d = carry_r_q;
      if (en) begin
        sum_r_d   = sum;
        carry_r_d = carry;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_r_q   <= '0;
        carry_r_q <= 1'b0;
      end else begin
        sum_r_q   <= sum_r_d;
        carry_r_q <= carry_r_d;
      end
    end

    assign sum_r   = sum_r_q;
    assign carry_r = carry_r_q;
  end else begin : g_noreg
    // Clock, reset and enable have no load when the registers are absent.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, en};
    assign sum_r     = '0;
    assign carry_r   = 1'b0;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at several widths against a behavioural model.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst, en;

  logic [0:0]  a1, b1;   logic c1;
  logic [7:0]  a8, b8;   logic c8;
  logic [15:0] a16, b16; logic c16;
  logic [3:0]  a4, b4;   logic c4;

  logic [0:0]  s1, sr1;   logic co1, cr1;
  logic [7:0]  s8, sr8;   logic co8, cr8;
  logic [15:0] s16, sr16; logic co16, cr16;
  logic [3:0]  s4, sr4;   logic co4, cr4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .carry(co1), .sum_r(sr1), .carry_r(cr1));
  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .carry(co8), .sum_r(sr8), .carry_r(cr8));
  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) dut16 (
    .clk(clk), .rst(rst), .en(en), .a(a16), .b(b16), .cin(c16),
    .sum(s16), .carry(co16), .sum_r(sr16), .carry_r(cr16));
  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) dut4 (
    .clk(clk), .rst(rst), .en(en), .a(a4), .b(b4), .cin(c4),
    .sum(s4), .carry(co4), .sum_r(sr4), .carry_r(cr4));

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural register model: {carry,sum} captured as plain integer addition.
  logic [1:0]  m1;
  logic [8:0]  m8;
  logic [16:0] m16;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m1 <= '0; m8 <= '0; m16 <= '0;
      model_valid <= 1'b1;
    end else if (en) begin
      m1  <= 2'(a1)   + 2'(b1)   + 2'(c1);
      m8  <= 9'(a8)   + 9'(b8)   + 9'(c8);
      m16 <= 17'(a16) + 17'(b16) + 17'(c16);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (model_valid) begin
        check("cmp_comb1",  {co1, s1},   2'(a1)   + 2'(b1)   + 2'(c1));
        check("cmp_comb8",  {co8, s8},   9'(a8)   + 9'(b8)   + 9'(c8));
        check("cmp_comb16", {co16, s16}, 17'(a16) + 17'(b16) + 17'(c16));
        check("cmp_comb4",  {co4, s4},   5'(a4)   + 5'(b4)   + 5'(c4));
        check("cmp_reg1",   {cr1, sr1},   m1);
        check("cmp_reg8",   {cr8, sr8},   m8);
        check("cmp_reg16",  {cr16, sr16}, m16);
        check("cmp_reg4_tied0", {cr4, sr4}, 5'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // {a,b,cin} -> {carry,sum}
  logic [2:0] vec_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b011, 3'b101, 3'b111, 3'b001};
  logic [1:0] vec_exp [8] = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b10,  2'b10,  2'b11,  2'b01};

  initial begin
    logic [2:0] v;
    rst = 1'b1; en = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0;
    a4 = '0; b4 = '0; c4 = 1'b0;

    // Pin the reference function with hand-computed results.
    check("ref_w16_wrap", fa_ref_sum(64'hFFFF, 64'h1, 1'b0, 16), 65'h1_0000);
    check("ref_w64_max",  fa_ref_sum('1, '1, 1'b1, 64), {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    check("ref_w8_mask",  fa_ref_sum(64'h1FF, 64'h001, 1'b1, 8), 65'h101);

    #2;
    for (int i = 0; i < 8; i++) begin
      v = vec_in[i];
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1;
      check($sformatf("w1_truth_%b", v), {co1, s1}, vec_exp[i]);
      #4;
    end

    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    #1; check("w8_ff_plus_01", {co8, s8}, {1'b1, 8'h00});
    #4;
    a8 = 8'h7F; b8 = 8'h80; c8 = 1'b1;
    #1; check("w8_7f_80_cin", {co8, s8}, {1'b1, 8'h00});
    #4;

    // Reset dominates enable; combinational path ignores reset.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_hold_reg", {cr1, sr1}, 2'b00);
      check("rst_comb",     {co1, s1},  2'b11);
    end

    @(negedge clk);
    rst = 1'b0; en = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk); #1;
    check("load_first_after_rst", {cr1, sr1}, 2'b01);
    @(negedge clk);
    en = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("en0_hold", {cr1, sr1}, 2'b01);
    end

    // Mid-cycle reset must not touch the registers before the edge.
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    #1; check("rst_no_async", {cr1, sr1}, 2'b01);
    @(posedge clk); #1;
    check("rst_and_en", {cr1, sr1}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("load_after_rst_drop", {cr1, sr1}, 2'b11);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
      a4  = 4'($urandom);  b4  = 4'($urandom);  c4  = 1'($urandom);
      a1  = 1'($urandom);  b1  = 1'($urandom);  c1  = 1'($urandom);
      #1;
      check("rnd_w16_ref", {co16, s16}, fa_ref_sum(64'(a16), 64'(b16), c16, 16));
    end

    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
    #1; check("w16_cin_ripple", {co16, s16}, 17'h1_0000);

    @(posedge clk); #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
